// File: rtl/mul_mod_arbiter.sv
`default_nettype none
// mul_mod_arbiter: round-robin arbiter/sequencer sharing one 64-bit (A*B) mod P unit
// between NUM_REQ requesters, with operand validation and a finish timeout. Rev 1.0
module mul_mod_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*64-1:0]   req_a_i,
  input  logic [NUM_REQ*64-1:0]   req_b_i,
  input  logic [NUM_REQ*64-1:0]   req_p_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  input  logic [NUM_REQ-1:0]      rsp_ready_i,
  output logic [63:0]             rsp_result_o,
  output logic                    rsp_err_o,
  output logic [63:0]             mul_a_o,
  output logic [63:0]             mul_b_o,
  output logic [63:0]             mul_p_o,
  output logic                    mul_start_o,
  input  logic                    mul_finish_i,
  input  logic [63:0]             mul_result_i,
  output logic                    busy_o,
  output logic [IDW-1:0]          grant_id_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] sel;
  logic           found;
  logic [CW-1:0]  cnt;
  logic [63:0]    op_a;
  logic [63:0]    op_b;
  logic [63:0]    op_p;
  logic [63:0]    result;
  logic           err;
  logic [63:0]    sel_a;
  logic [63:0]    sel_b;
  logic [63:0]    sel_p;
  logic           operands_ok;
  logic           timed_out;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin : arb
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        sel   = idx[IDW-1:0];
      end
    end
  end

  assign sel_a       = req_a_i[64*int'(sel) +: 64];
  assign sel_b       = req_b_i[64*int'(sel) +: 64];
  assign sel_p       = req_p_i[64*int'(sel) +: 64];
  assign operands_ok = (sel_p != 64'd0) && (sel_a < sel_p) && (sel_b < sel_p);
  assign timed_out   = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = '0;
    rsp_valid_o = '0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready_o[sel] = 1'b1;
          state_nxt        = operands_ok ? START : RESP;
        end
      end
      START: state_nxt = WAIT;
      // Finish wins over a timeout landing in the same cycle.
      WAIT: begin
        if (mul_finish_i || timed_out) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid_o[grant] = 1'b1;
        if (rsp_ready_i[grant]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
      grant  <= '0;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_p   <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_p   <= sel_p;
            grant  <= sel;
            result <= '0;
            err    <= !operands_ok;
          end
        end
        START: cnt <= '0;
        WAIT: begin
          if (mul_finish_i) begin
            result <= mul_result_i;
            err    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (timed_out) begin
              result <= '0;
              err    <= 1'b1;
            end
          end
        end
        RESP: begin
          if (rsp_ready_i[grant]) begin
            rr_ptr <= (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_a_o      = op_a;
  assign mul_b_o      = op_b;
  assign mul_p_o      = op_p;
  assign mul_start_o  = (state == START);
  assign busy_o       = (state != IDLE);
  assign grant_id_o   = grant;
  assign rsp_result_o = result;
  assign rsp_err_o    = err;

endmodule
`default_nettype wire

// File: tb/tb_mul_mod_arbiter.sv
`default_nettype none
// tb_mul_mod_arbiter: scoreboard bench for mul_mod_arbiter with a one-cycle multiplier stub.
module tb_mul_mod_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*64-1:0] req_a, req_b, req_p;
  logic [63:0] rsp_result, mul_a, mul_b, mul_p, mul_result;
  logic rsp_err, mul_start, mul_finish, busy;
  logic [1:0] grant_id;

  int vectors = 0;
  int miscompares = 0;
  int unsigned tick = 0;

  typedef struct {int id; logic [63:0] res; logic err;} exp_t;
  exp_t sb[$];

  // Multiplier stub: finish one cycle after the start cycle, or manual control when disabled.
  logic stub_en = 1'b1;
  logic stub_pend = 1'b0;
  logic stub_fin = 1'b0;
  logic [63:0] stub_res = '0;
  logic man_fin = 1'b0;
  logic [63:0] man_res = '0;
  assign mul_finish = stub_en ? stub_fin : man_fin;
  assign mul_result = stub_en ? stub_res : man_res;

  mul_mod_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_p_i(req_p),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_err_o(rsp_err),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_p_o(mul_p),
    .mul_start_o(mul_start), .mul_finish_i(mul_finish), .mul_result_i(mul_result),
    .busy_o(busy), .grant_id_o(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  function automatic logic [63:0] mulmod(logic [63:0] a, logic [63:0] b, logic [63:0] p);
    logic [127:0] t;
    logic [127:0] r;
    t = {64'd0, a} * {64'd0, b};
    r = t % {64'd0, p};
    return r[63:0];
  endfunction

  function automatic exp_t expect_op(int id, logic [63:0] a, logic [63:0] b, logic [63:0] p);
    exp_t e;
    e.id = id;
    if (p == 64'd0 || a >= p || b >= p) begin
      e.res = 64'd0;
      e.err = 1'b1;
    end else begin
      e.res = mulmod(a, b, p);
      e.err = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (stub_en) begin
      stub_fin  = stub_pend;
      stub_res  = stub_pend ? mulmod(mul_a, mul_b, mul_p) : 64'hDEAD_BEEF_0000_0000;
      stub_pend = mul_start;
    end else begin
      stub_pend = 1'b0;
      stub_fin  = 1'b0;
    end
  end

  task automatic set_req(int k, logic [63:0] a, logic [63:0] b, logic [63:0] p);
    req_a[64*k +: 64] = a;
    req_b[64*k +: 64] = b;
    req_p[64*k +: 64] = p;
  endtask

  // Advances cycle by cycle until a response appears; cyc is the cycle count since accept.
  task automatic wait_rsp(input int limit, input logic [N-1:0] hold, output int cyc,
                          output int starts, output int start_cyc);
    cyc = 0; starts = 0; start_cyc = -1;
    while (cyc < limit) begin
      @(negedge clk);
      if (cyc == 0) req_valid = hold;
      cyc++;
      if (mul_start) begin
        starts++;
        if (start_cyc < 0) start_cyc = cyc;
      end
      if (rsp_valid != '0) break;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, rsp_result, rsp_err, mul_a, mul_b, mul_p, mul_start, busy, grant_id} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b rsp_valid=%b result=%h err=%b start=%b busy=%b grant=%0d, all must be 0",
               req_ready, rsp_valid, rsp_result, rsp_err, mul_start, busy, grant_id);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    exp_t e;
    int accepts = 0;
    int id;
    int unsigned last = 0;
    for (int k = 0; k < N; k++) set_req(k, 64'd2, 64'd3, 64'd11);
    req_valid = '1;
    rsp_ready = '1;
    #1;
    for (int c = 0; c < 60 && (accepts < 5 || sb.size() > 0); c++) begin
      if (req_ready != '0) begin
        id = -1;
        for (int k = 0; k < N; k++) if (req_ready[k]) id = k;
        vectors++;
        if (id != accepts % N) begin
          miscompares++;
          $display("FAIL rr_order: accept %0d got id %0d want %0d", accepts, id, accepts % N);
        end
        if (accepts > 0) begin
          vectors++;
          if (tick - last != 4) begin
            miscompares++;
            $display("FAIL rr_spacing: got %0d cycles want 4", tick - last);
          end
        end
        last = tick;
        sb.push_back(expect_op(id, 64'd2, 64'd3, 64'd11));
        accepts++;
      end
      if (rsp_valid != '0) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rr_unexpected_rsp: rsp_valid=%b with empty scoreboard", rsp_valid);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== (N'(1) << e.id) || rsp_result !== e.res || rsp_err !== e.err) begin
            miscompares++;
            $display("FAIL rr_rsp: got valid=%b result=%0d err=%b want valid=%b result=%0d err=%b",
                     rsp_valid, rsp_result, rsp_err, N'(1) << e.id, e.res, e.err);
          end
        end
      end
      @(negedge clk);
      if (accepts >= 5) req_valid = '0;
      #1;
    end
    vectors++;
    if (accepts != 5 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL rr_complete: got %0d accepts, %0d pending, want 5 and 0", accepts, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    exp_t e;
    int cyc, starts, scyc;
    set_req(0, 64'd3, 64'd5, 64'd7);
    req_valid = 4'b0001;
    rsp_ready = '0;
    sb.push_back(expect_op(0, 64'd3, 64'd5, 64'd7));
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    wait_rsp(10, '0, cyc, starts, scyc);
    vectors++;
    if (cyc != 3 || starts != 1 || scyc != 1) begin
      miscompares++;
      $display("FAIL single_timing: rsp cycle %0d starts %0d start cycle %0d, want 3 1 1", cyc, starts, scyc);
    end
    e = sb.pop_front();
    vectors++;
    if (rsp_valid !== (N'(1) << e.id) || rsp_result !== e.res || rsp_err !== e.err) begin
      miscompares++;
      $display("FAIL single_rsp: got valid=%b result=%0d err=%b want valid=%b result=%0d err=%b",
               rsp_valid, rsp_result, rsp_err, N'(1) << e.id, e.res, e.err);
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
    rsp_ready = '0;
  endtask

  task automatic test_operand_errors();
    exp_t e;
    int cyc, starts, scyc;
    logic [63:0] vals [2][3];
    int ids [2];
    vals[0][0] = 64'd0;  vals[0][1] = 64'd0; vals[0][2] = 64'd0;
    vals[1][0] = 64'd13; vals[1][1] = 64'd1; vals[1][2] = 64'd13;
    ids[0] = 2; ids[1] = 3;
    rsp_ready = '1;
    for (int t = 0; t < 2; t++) begin
      set_req(ids[t], vals[t][0], vals[t][1], vals[t][2]);
      req_valid = N'(1) << ids[t];
      sb.push_back(expect_op(ids[t], vals[t][0], vals[t][1], vals[t][2]));
      #1;
      vectors++;
      if (req_ready !== (N'(1) << ids[t])) begin
        miscompares++;
        $display("FAIL operr%0d_ready: got %b want %b", t, req_ready, N'(1) << ids[t]);
      end
      wait_rsp(10, '0, cyc, starts, scyc);
      vectors++;
      if (cyc != 1 || starts != 0) begin
        miscompares++;
        $display("FAIL operr%0d_timing: rsp cycle %0d starts %0d want 1 0", t, cyc, starts);
      end
      e = sb.pop_front();
      vectors++;
      if (rsp_valid !== (N'(1) << e.id) || rsp_result !== e.res || rsp_err !== e.err) begin
        miscompares++;
        $display("FAIL operr%0d_rsp: got valid=%b result=%0d err=%b want valid=%b result=%0d err=%b",
                 t, rsp_valid, rsp_result, rsp_err, N'(1) << e.id, e.res, e.err);
      end
      @(negedge clk);
    end
    rsp_ready = '0;
  endtask

  task automatic test_timeout();
    exp_t e;
    int cyc, starts, scyc;
    stub_en = 1'b0;
    set_req(1, 64'd2, 64'd3, 64'd11);
    req_valid = 4'b0010;
    e.id = 1; e.res = 64'd0; e.err = 1'b1;
    sb.push_back(e);
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL timeout_ready: got %b want 0010", req_ready);
    end
    wait_rsp(40, '0, cyc, starts, scyc);
    vectors++;
    if (cyc != TO + 2 || starts != 1) begin
      miscompares++;
      $display("FAIL timeout_timing: rsp cycle %0d starts %0d want %0d 1", cyc, starts, TO + 2);
    end
    e = sb.pop_front();
    vectors++;
    if (rsp_valid !== (N'(1) << e.id) || rsp_result !== e.res || rsp_err !== e.err) begin
      miscompares++;
      $display("FAIL timeout_rsp: got valid=%b result=%0d err=%b want valid=%b result=%0d err=%b",
               rsp_valid, rsp_result, rsp_err, N'(1) << e.id, e.res, e.err);
    end
    man_fin = 1'b1;
    man_res = 64'h1234;
    @(negedge clk);
    man_fin = 1'b0;
    vectors++;
    if (rsp_valid !== 4'b0010 || rsp_result !== 64'd0 || rsp_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_stray_finish: got valid=%b result=%h err=%b want 0010 0 1", rsp_valid, rsp_result, rsp_err);
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = '0;
    stub_en = 1'b1;
    vectors++;
    if (rsp_valid !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_done: got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int cyc, starts, scyc;
    logic [63:0] held;
    set_req(0, 64'd4, 64'd5, 64'd7);
    set_req(1, 64'd1, 64'd1, 64'd3);
    req_valid = 4'b0011;
    sb.push_back(expect_op(0, 64'd4, 64'd5, 64'd7));
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL bp_first_ready: got %b want 0001", req_ready);
    end
    wait_rsp(10, 4'b0010, cyc, starts, scyc);
    e = sb.pop_front();
    vectors++;
    if (cyc != 3 || rsp_valid !== 4'b0001 || rsp_result !== e.res || rsp_err !== e.err) begin
      miscompares++;
      $display("FAIL bp_rsp: cycle %0d valid=%b result=%0d err=%b want 3 0001 %0d %b",
               cyc, rsp_valid, rsp_result, rsp_err, e.res, e.err);
    end
    held = e.res;
    rsp_ready = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 4'b0001 || rsp_result !== held || rsp_err !== 1'b0 || req_ready !== '0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: valid=%b result=%0d err=%b ready=%b want 0001 %0d 0 0000",
                 c, rsp_valid, rsp_result, rsp_err, req_ready, held);
      end
    end
    rsp_ready = 4'b0001;
    #1;
    vectors++;
    if (req_ready !== '0) begin
      miscompares++;
      $display("FAIL bp_handshake_ready: got %b want 0000", req_ready);
    end
    sb.push_back(expect_op(1, 64'd1, 64'd1, 64'd3));
    @(negedge clk);
    rsp_ready = 4'b0010;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_next_ready: got %b want 0010", req_ready);
    end
    wait_rsp(10, '0, cyc, starts, scyc);
    e = sb.pop_front();
    vectors++;
    if (cyc != 3 || rsp_valid !== (N'(1) << e.id) || rsp_result !== e.res || rsp_err !== e.err) begin
      miscompares++;
      $display("FAIL bp_second_rsp: cycle %0d valid=%b result=%0d err=%b want 3 %b %0d %b",
               cyc, rsp_valid, rsp_result, rsp_err, N'(1) << e.id, e.res, e.err);
    end
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    int cyc, starts, scyc;
    logic [N-1:0] seen;
    stub_en = 1'b0;
    set_req(2, 64'd2, 64'd3, 64'd11);
    req_valid = 4'b0100;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL rstw_ready: got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || mul_start !== 1'b0) begin
      miscompares++;
      $display("FAIL rstw_in_wait: busy=%b start=%b want 1 0", busy, mul_start);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stub_en = 1'b1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_result, rsp_err, mul_a, mul_b, mul_p, mul_start, busy, grant_id} !== '0) begin
      miscompares++;
      $display("FAIL rstw_outputs: ready=%b rsp_valid=%b result=%h err=%b start=%b busy=%b grant=%0d, all must be 0",
               req_ready, rsp_valid, rsp_result, rsp_err, mul_start, busy, grant_id);
    end
    rsp_ready = '1;
    seen = '0;
    repeat (6) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    vectors++;
    if (seen !== '0) begin
      miscompares++;
      $display("FAIL rstw_dropped: got rsp_valid %b after reset want 0000", seen);
    end
    set_req(1, 64'd2, 64'd3, 64'd11);
    set_req(3, 64'd2, 64'd3, 64'd11);
    req_valid = 4'b1010;
    sb.push_back(expect_op(1, 64'd2, 64'd3, 64'd11));
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL rstw_ptr: got ready %b want 0010", req_ready);
    end
    wait_rsp(10, '0, cyc, starts, scyc);
    e = sb.pop_front();
    vectors++;
    if (cyc != 3 || rsp_valid !== (N'(1) << e.id) || rsp_result !== e.res || rsp_err !== e.err) begin
      miscompares++;
      $display("FAIL rstw_rsp: cycle %0d valid=%b result=%0d err=%b want 3 %b %0d %b",
               cyc, rsp_valid, rsp_result, rsp_err, N'(1) << e.id, e.res, e.err);
    end
    @(negedge clk);
    rsp_ready = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    req_p = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_operand_errors();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_mod_arbiter.md
# mul_mod_arbiter

Round-robin arbiter and sequencer that shares one `mul_modular_unit` (64-bit `(A*B) mod P`) between `NUM_REQ` requesters in the ECC accelerator, such as the point-add and point-double sequencers. It performs these steps for each operation:
- accepts a request over a valid/ready handshake;
- validates the operands;
- pulses the multiplier start;
- waits for finish, with a timeout;
- returns the result to the winning requester over a held valid/ready response.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 16: number of WAIT cycles allowed before the operation aborts; must be ≥ 2.

Ports (`IDW = $clog2(NUM_REQ)`):
- `clk_i`, in, 1: clock. Single clock domain.
- `rst_ni`, in, 1: reset. **Synchronous, active-low.**
- `req_valid_i`, in, `NUM_REQ`: per-requester request valid.
- `req_ready_o`, out, `NUM_REQ`: per-requester accept. At most one bit is high at a time.
- `req_a_i`, `req_b_i`, `req_p_i`, in, `NUM_REQ*64` each: packed operands. Requester k uses bits `[64k+63:64k]`.
- `rsp_valid_o`, out, `NUM_REQ`: per-requester response valid. At most one bit is high at a time.
- `rsp_ready_i`, in, `NUM_REQ`: per-requester response accept.
- `rsp_result_o`, out, 64: shared result bus. Meaningful only while some bit of `rsp_valid_o` is high.
- `rsp_err_o`, out, 1: error flag for the current response (invalid operands or timeout).
- `mul_a_o`, `mul_b_o`, `mul_p_o`, out, 64 each: multiplier operands, driven from registers.
- `mul_start_o`, out, 1: multiplier start, a single-cycle pulse.
- `mul_finish_i`, in, 1: multiplier done.
- `mul_result_i`, in, 64: multiplier result.
- `busy_o`, out, 1: high in every state except IDLE.
- `grant_id_o`, out, `IDW`: index of the requester currently owning the unit.

## Operation

- FSM states: IDLE, START, WAIT, RESP.
- **IDLE**
  - Select the first k with `req_valid_i[k]` high, scanning upward from pointer `rr_ptr` and wrapping modulo `NUM_REQ`.
  - Drive `req_ready_o[k]=1` combinationally in the same cycle. The handshake completes in that cycle.
  - Register `a`, `b`, `p` and `grant_id_o`=k.
- **Operand check** (evaluated on the accepted values in IDLE):
  - Check fails if `p==0`, or `a>=p`, or `b>=p`.
  - On failure: go directly to RESP with result 0 and err=1. The multiplier is never started.
  - On pass: go to START.
- **START** (exactly one cycle)
  - `mul_start_o=1`.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT**
  - `mul_start_o=0`.
  - If `mul_finish_i=1`: register `mul_result_i`, set err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`: set result 0, err=1, go to RESP.
  - Finish takes priority over timeout if both occur in the same cycle.
- **RESP**
  - Hold `rsp_valid_o[grant]=1`. Result and err stay stable until `rsp_ready_i[grant]=1`.
  - On that handshake: set `rr_ptr=(grant+1) mod NUM_REQ` and go to IDLE.
  - `rsp_ready_i` bits of other requesters are ignored.
- **Ignored inputs**
  - `mul_finish_i` is ignored in IDLE, START and RESP. A stale pulse must not complete a later operation.
  - `req_valid_i` is ignored outside IDLE, and `req_ready_o` is all-zero outside IDLE.
- **Fairness**
  - The pointer advances only on response completion, including error responses.
  - A requester that holds valid is served within `NUM_REQ` operations.

## Timing

- **Reset values:** state IDLE, `rr_ptr=0`, counter 0. Every output is 0: `req_ready_o`, `rsp_valid_o`, `rsp_result_o`, `rsp_err_o`, `mul_*_o`, `mul_start_o`, `busy_o`, `grant_id_o`.
- **Reset mid-operation:** returns to IDLE on the next edge. Any in-flight request and response is dropped, and the requester must reissue.
- **Nominal latency** with a multiplier that raises finish the cycle after start:
  - accept in cycle 0;
  - `mul_start_o` in cycle 1;
  - finish sampled in cycle 2;
  - `rsp_valid_o` from cycle 3.
- **Error latency:** accept in cycle 0, `rsp_valid_o` in cycle 1.
- **Timeout:** `rsp_valid_o` rises `TIMEOUT+2` cycles after accept.
- **Throughput:** at most one operation per 4 cycles. The earliest next accept is the cycle after the response handshake, because IDLE is re-entered with no bypass.

## Test plan

- **Single multiply.** Requester 0 sends a=3, b=5, p=7. Required:
  - `req_ready_o[0]` high in cycle 0;
  - `mul_start_o` high in cycle 1 only;
  - `rsp_valid_o[0]` high in cycle 3 with result 1, err 0.
- **Round-robin contention.** All 4 requesters hold valid continuously, each sending a=2, b=3, p=11. Required grant order 0,1,2,3,0. Every result is 6, and successive accepts are 4 cycles apart.
- **Operand errors.**
  - p=0 → err=1, result 0, in cycle 1, with no `mul_start_o`.
  - a=13, b=1, p=13 → err=1, result 0, in cycle 1, with no `mul_start_o`.
- **Timeout.** Multiplier stub never asserts finish, `TIMEOUT`=16. Required: `rsp_valid_o` with err=1 at cycle 18 after accept. A stray finish pulse during the following RESP is ignored.
- **Response backpressure.** Hold `rsp_ready_i` low for 5 cycles with requester 1 also valid. Required:
  - the result stays stable throughout;
  - `req_ready_o[1]` stays 0 until the cycle after the handshake.
- **Reset in WAIT.** Assert `rst_ni=0` for one cycle during WAIT. Required: all outputs 0 on the next edge, `rr_ptr=0`, and no response is issued for the dropped request.
